// File: rtl/fft_peak_rx.sv
// -----------------------------------------------------------------------------
// fft_peak_rx
//
// Receives one FFT output frame bin by bin. For each bin it computes the squared
// magnitude re^2+im^2 and keeps the largest bin inside [MIN_BIN, MAX_BIN]. At the
// end of the frame it reports the peak bin index and magnitude as a one-cycle
// result pulse.
//
// Ports:
//   clk_100mhz  in   system clock
//   rst         in   synchronous, active-high reset
//   s_tdata     in   [15:0] real, [31:16] imag, both two's complement
//   s_tvalid    in   bin valid
//   s_tlast     in   last bin of frame
//   s_tready    out  receiver can accept a bin (depends on state only)
//   peak_bin    out  index of the largest in-range bin
//   peak_mag    out  re^2+im^2 of that bin, unsigned
//   peak_valid  out  one-cycle pulse qualifying peak_bin/peak_mag/frame_err
//   frame_err   out  frame length was not FRAMESIZE
//
// Timing: the frame-end transfer happens in cycle T. peak_valid is high in
// cycle T+4, s_tready is low in T+1..T+4 and high again in T+5.
// -----------------------------------------------------------------------------
module fft_peak_rx #(
  parameter int FRAMESIZE = 2048,
  parameter int MIN_BIN   = 1,
  parameter int MAX_BIN   = FRAMESIZE / 2 - 1
) (
  input  logic                         clk_100mhz,
  input  logic                         rst,
  input  logic [31:0]                  s_tdata,
  input  logic                         s_tvalid,
  input  logic                         s_tlast,
  output logic                         s_tready,
  output logic [$clog2(FRAMESIZE)-1:0] peak_bin,
  output logic [31:0]                  peak_mag,
  output logic                         peak_valid,
  output logic                         frame_err
);

  localparam int             BW       = $clog2(FRAMESIZE);
  localparam logic [BW-1:0]  LAST_IDX = BW'(FRAMESIZE - 1);

  typedef enum logic [1:0] {
    RECV,
    FLUSH,
    REPORT
  } state_t;

  // Squares a 16-bit signed component. The largest result is (-32768)^2 =
  // 2^30, which fits comfortably in 32 unsigned bits.
  function automatic logic [31:0] f_square(input logic signed [15:0] x);
    logic signed [31:0] xe;
    xe = 32'(x);
    return xe * xe;
  endfunction

  // Peak search window test for a bin tag.
  function automatic logic f_in_range(input logic [BW-1:0] b);
    return (int'(b) >= MIN_BIN) && (int'(b) <= MAX_BIN);
  endfunction

  // Control state
  state_t        r_state;
  logic [BW-1:0] r_cnt;
  logic [1:0]    r_flush_cnt;
  logic          r_err;
  logic [31:0]   r_max;
  logic [BW-1:0] r_max_bin;

  // Data pipeline (no reset; qualified by the valid bits)
  logic [31:0]   r_sq_re_p1;
  logic [31:0]   r_sq_im_p1;
  logic [BW-1:0] r_bin_p1;
  logic          r_inr_p1;
  logic          r_vld_p1;
  logic [31:0]   r_sum_p2;
  logic [BW-1:0] r_bin_p2;
  logic          r_inr_p2;
  logic          r_vld_p2;

  logic signed [15:0] w_re;
  logic signed [15:0] w_im;
  logic               w_xfer;
  logic               w_at_last_idx;
  logic               w_frame_end;
  logic               w_len_err;

  assign w_re          = s_tdata[15:0];
  assign w_im          = s_tdata[31:16];
  assign s_tready      = (r_state == RECV) && !rst;
  assign w_xfer        = s_tvalid && s_tready;
  assign w_at_last_idx = (r_cnt == LAST_IDX);
  // The frame closes on tlast or on the FRAMESIZE-th bin, whichever comes first.
  assign w_frame_end   = s_tlast || w_at_last_idx;
  // Length is wrong when tlast and the final count index disagree.
  assign w_len_err     = s_tlast != w_at_last_idx;

  // ---- stage 1: component squares, tagged with bin index ----
  // ---- stage 2: magnitude sum (max 2^31, no overflow) ----
  always_ff @(posedge clk_100mhz) begin
    if (w_xfer) begin
      r_sq_re_p1 <= f_square(w_re);
      r_sq_im_p1 <= f_square(w_im);
      r_bin_p1   <= r_cnt;
      r_inr_p1   <= f_in_range(r_cnt);
    end
    if (r_vld_p1) begin
      r_sum_p2 <= r_sq_re_p1 + r_sq_im_p1;
      r_bin_p2 <= r_bin_p1;
      r_inr_p2 <= r_inr_p1;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_xfer;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- stage 3: running max compare, frame control and reporting ----
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_state     <= RECV;
      r_cnt       <= '0;
      r_flush_cnt <= '0;
      r_err       <= 1'b0;
      r_max       <= '0;
      r_max_bin   <= '0;
      peak_bin    <= '0;
      peak_mag    <= '0;
      peak_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      peak_valid <= 1'b0;

      // Strict compare: on equal magnitudes the earlier (lower) bin is kept.
      if (r_vld_p2 && r_inr_p2 && (r_sum_p2 > r_max)) begin
        r_max     <= r_sum_p2;
        r_max_bin <= r_bin_p2;
      end

      case (r_state)
        RECV: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + BW'(1);
            if (w_len_err) begin
              r_err <= 1'b1;
            end
            if (w_frame_end) begin
              r_state     <= FLUSH;
              r_flush_cnt <= '0;
            end
          end
        end

        // Three idle cycles let the last bin reach the running max.
        FLUSH: begin
          if (r_flush_cnt == 2'd2) begin
            r_state    <= REPORT;
            peak_valid <= 1'b1;
            peak_bin   <= r_max_bin;
            peak_mag   <= r_max;
            frame_err  <= r_err;
          end else begin
            r_flush_cnt <= r_flush_cnt + 2'd1;
          end
        end

        // Pipeline is empty here, so clearing cannot race a compare update.
        REPORT: begin
          r_state   <= RECV;
          r_max     <= '0;
          r_max_bin <= '0;
          r_cnt     <= '0;
          r_err     <= 1'b0;
        end

        default: begin
          r_state <= RECV;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_rx.sv
// -----------------------------------------------------------------------------
// tb_fft_peak_rx
//
// Directed bench for fft_peak_rx with FRAMESIZE=16, search window bins 1..7.
// Frames are built in the fre/fim tables, streamed bin by bin, and the report
// timing and values are compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_fft_peak_rx;

  logic        clk_100mhz;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [3:0]  peak_bin;
  logic [31:0] peak_mag;
  logic        peak_valid;
  logic        frame_err;

  int checks;
  int errors;
  int pv_cnt;
  int pv_base;

  logic [15:0] fre [16];
  logic [15:0] fim [16];

  fft_peak_rx #(
    .FRAMESIZE(16),
    .MIN_BIN  (1),
    .MAX_BIN  (7)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag),
    .peak_valid(peak_valid),
    .frame_err (frame_err)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  always @(negedge clk_100mhz) begin
    if (peak_valid === 1'b1) pv_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic clear_bins();
    for (int i = 0; i < 16; i++) begin
      fre[i] = 16'd0;
      fim[i] = 16'd0;
    end
  endtask

  // Called mid-cycle; returns mid-cycle just after the transfer edge.
  task automatic beat(input logic [31:0] d, input logic last);
    int guard;
    guard = 0;
    while (s_tready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) chk("tready_wait", 64'(s_tready), 64'd1);
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 32'hDEAD_BEEF;
  endtask

  task automatic send_frame(input int n, input int last_idx, input bit gaps);
    for (int i = 0; i < n; i++) begin
      beat({fim[i], fre[i]}, (i == last_idx));
      if (gaps && i < n - 1) begin
        repeat ($urandom_range(0, 2)) step();
      end
    end
  endtask

  // Entered in cycle T+1 right after the frame-end transfer.
  task automatic check_report(input string tag, input logic [3:0] eb,
                              input logic [31:0] em, input logic ee);
    chk({tag, "_rdy_t1"}, 64'(s_tready), 64'd0);
    chk({tag, "_pv_t1"}, 64'(peak_valid), 64'd0);
    step();
    chk({tag, "_pv_t2"}, 64'(peak_valid), 64'd0);
    step();
    chk({tag, "_rdy_t3"}, 64'(s_tready), 64'd0);
    chk({tag, "_pv_t3"}, 64'(peak_valid), 64'd0);
    step();
    chk({tag, "_pv_t4"}, 64'(peak_valid), 64'd1);
    chk({tag, "_rdy_t4"}, 64'(s_tready), 64'd0);
    chk({tag, "_bin"}, 64'(peak_bin), 64'(eb));
    chk({tag, "_mag"}, 64'(peak_mag), 64'(em));
    chk({tag, "_err"}, 64'(frame_err), 64'(ee));
    step();
    chk({tag, "_rdy_t5"}, 64'(s_tready), 64'd1);
    chk({tag, "_pv_t5"}, 64'(peak_valid), 64'd0);
    chk({tag, "_mag_hold"}, 64'(peak_mag), 64'(em));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    pv_cnt   = 0;
    rst      = 1'b1;
    s_tdata  = 32'd0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_rdy", 64'(s_tready), 64'd0);
    chk("rst_pv", 64'(peak_valid), 64'd0);
    chk("rst_bin", 64'(peak_bin), 64'd0);
    chk("rst_mag", 64'(peak_mag), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(s_tready), 64'd1);

    // 1: single peak at bin 3, 100^2 + 200^2 = 50000
    clear_bins();
    fre[3] = 16'd100;
    fim[3] = -16'sd200;
    send_frame(16, 15, 1'b0);
    check_report("s1", 4'd3, 32'd50000, 1'b0);

    // 2: tie between bins 2 and 5 (250000); DC and mirrored bins larger but excluded
    clear_bins();
    fre[0] = 16'd30000;
    fre[2] = 16'd300;
    fim[2] = 16'd400;
    fre[5] = 16'd500;
    fre[9] = 16'd32767;
    fim[9] = 16'd32767;
    send_frame(16, 15, 1'b0);
    check_report("s2", 4'd2, 32'd250000, 1'b0);

    // 3: full-scale negative components, 2*2^30 = 2^31
    clear_bins();
    fre[4] = 16'h8000;
    fim[4] = 16'h8000;
    send_frame(16, 15, 1'b0);
    check_report("s3", 4'd4, 32'd2147483648, 1'b0);

    // 4a: early tlast on bin 9; bin 5 = (3,4) -> 25
    clear_bins();
    fre[5] = 16'd3;
    fim[5] = 16'd4;
    send_frame(10, 9, 1'b0);
    check_report("s4a", 4'd5, 32'd25, 1'b1);

    // 4b: correct frame restarts counting at 0; bin 1 = (1,0) -> 1
    clear_bins();
    fre[1] = 16'd1;
    send_frame(16, 15, 1'b0);
    check_report("s4b", 4'd1, 32'd1, 1'b0);

    // 5a: 16 bins without tlast; bin 7 = (0,-1) -> 1
    clear_bins();
    fim[7] = 16'hFFFF;
    send_frame(16, -1, 1'b0);
    check_report("s5a", 4'd7, 32'd1, 1'b1);

    // 5b: scenario 1 again with random source gaps
    clear_bins();
    fre[3] = 16'd100;
    fim[3] = -16'sd200;
    send_frame(16, 15, 1'b1);
    check_report("s5b", 4'd3, 32'd50000, 1'b0);

    // 6: reset after bin 7 of a frame that holds a large bin 2
    clear_bins();
    fre[2] = 16'd1000;
    fim[2] = 16'd1000;
    pv_base = pv_cnt;
    send_frame(8, -1, 1'b0);
    rst = 1'b1;
    #1;
    chk("s6_rst_rdy", 64'(s_tready), 64'd0);
    step();
    chk("s6_rst_pv", 64'(peak_valid), 64'd0);
    chk("s6_rst_bin", 64'(peak_bin), 64'd0);
    chk("s6_rst_mag", 64'(peak_mag), 64'd0);
    chk("s6_rst_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    #1;
    chk("s6_post_rdy", 64'(s_tready), 64'd1);
    chk("s6_post_pv", 64'(peak_valid), 64'd0);
    chk("s6_post_mag", 64'(peak_mag), 64'd0);
    clear_bins();
    fre[6] = 16'd10;
    fim[6] = 16'd10;
    send_frame(16, 15, 1'b0);
    check_report("s6", 4'd6, 32'd200, 1'b0);
    repeat (6) step();
    chk("s6_pulse_count", 64'(pv_cnt - pv_base), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
